// File: rtl/pht_update_sched_pkg.sv
// Shared constants and types for the PHT update scheduler.
//   GSH_PHT_SEL      : PHT index width (2^GSH_PHT_SEL two-bit counters)
//   PHT_FIFO_DEPTH   : default number of buffered update entries
//   PHT_SCRUB_PASSES : default number of full PHT sweeps per scrub
package pht_update_sched_pkg;

  localparam int GSH_PHT_SEL      = 10;
  localparam int PHT_FIFO_DEPTH   = 4;
  localparam int PHT_SCRUB_PASSES = 3;

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic                   cond;
    logic [GSH_PHT_SEL-1:0] ent;
  } pht_upd_t;

endpackage

// File: rtl/pht_upd_fifo.sv
// Two-write / one-read FIFO of {cond, ent} PHT update entries.
//   clk, reset          : clock, asynchronous active-low reset
//   i_wr0_en/i_wr0_data : first write port (lands first in FIFO order)
//   i_wr1_en/i_wr1_data : second write port (lands after port 0 when both write)
//   i_rd_en             : pop the head entry
//   o_rd_data           : current head entry
//   o_count             : occupancy
// The caller guarantees no overflow/underflow; pointers wrap modulo DEPTH.
module pht_upd_fifo
  import pht_update_sched_pkg::*;
#(
  parameter int DEPTH = PHT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr0_en,
  input  pht_upd_t                 i_wr0_data,
  input  logic                     i_wr1_en,
  input  pht_upd_t                 i_wr1_data,
  input  logic                     i_rd_en,
  output pht_upd_t                 o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pht_upd_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_wptr_p1;

  assign w_wptr_p1 = r_wptr + PW'(1);

  // When only port 1 writes it takes the current write slot.
  always_ff @(posedge clk) begin
    if (i_wr0_en) r_mem[r_wptr] <= i_wr0_data;
    if (i_wr1_en) r_mem[i_wr0_en ? w_wptr_p1 : r_wptr] <= i_wr1_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(i_wr0_en) + PW'(i_wr1_en);
      r_rptr  <= r_rptr + PW'(i_rd_en);
      r_count <= r_count + CW'(i_wr0_en) + CW'(i_wr1_en) - CW'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;

endmodule

// File: rtl/pht_update_sched.sv
// PHT update scheduler: scrubs the gshare PHT to all-zero counters after
// reset or on request, then drains buffered branch-resolution updates from
// two branch units into the PHT write port, one per cycle.
//   clk, reset                          : clock, asynchronous active-low reset
//   req{0,1}_valid/_cond/_ent/_ready    : update request handshakes
//   scrub_req                           : pulse to start a scrub (ignored in SCRUB)
//   pht_we/pht_wcond/pht_went           : registered PHT write port
//   scrub_busy                          : high while scrubbing
//   fifo_count                          : buffered entry count
//
// state    | meaning
// ST_SCRUB | writing not-taken to every PHT index, SCRUB_PASSES sweeps
// ST_RUN   | accepting requests and draining the FIFO
module pht_update_sched
  import pht_update_sched_pkg::*;
#(
  parameter int FIFO_DEPTH   = PHT_FIFO_DEPTH,
  parameter int SCRUB_PASSES = PHT_SCRUB_PASSES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  input  logic                          req0_cond,
  input  logic [GSH_PHT_SEL-1:0]        req0_ent,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic                          req1_cond,
  input  logic [GSH_PHT_SEL-1:0]        req1_ent,
  output logic                          req1_ready,
  input  logic                          scrub_req,
  output logic                          pht_we,
  output logic                          pht_wcond,
  output logic [GSH_PHT_SEL-1:0]        pht_went,
  output logic                          scrub_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PCW = $clog2(SCRUB_PASSES + 1);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  logic [GSH_PHT_SEL-1:0] r_scrub_addr;
  logic [PCW-1:0]         r_pass_cnt;
  logic                   r_pht_we;
  logic                   r_pht_wcond;
  logic [GSH_PHT_SEL-1:0] r_pht_went;
  logic [CW-1:0]          w_count;
  pht_upd_t               w_head;
  logic                   w_scrub_done;
  logic                   w_scrub_wr;
  logic                   w_deq;
  logic                   w_acc0;
  logic                   w_acc1;

  // The last sweep's final write has already been issued once the pass count
  // reaches SCRUB_PASSES; the following edge leaves SCRUB.
  assign w_scrub_done = (r_pass_cnt == PCW'(SCRUB_PASSES));
  assign w_scrub_wr   = (r_state == ST_SCRUB) && !w_scrub_done;

  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_SCRUB: begin
        if (w_scrub_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Ready looks only at the registered count, never at this cycle's dequeue.
        req0_ready = (w_count <  CW'(FIFO_DEPTH));
        req1_ready = (w_count <= CW'(FIFO_DEPTH - 2));
        if (scrub_req) w_state_nxt = ST_SCRUB;
        else           w_deq       = (w_count != '0);
      end
      default: w_state_nxt = ST_SCRUB;
    endcase
  end

  assign w_acc0 = req0_valid && req0_ready;
  assign w_acc1 = req1_valid && req1_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_SCRUB;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scrub_addr <= '0;
      r_pass_cnt   <= '0;
    end else if ((r_state == ST_RUN) && scrub_req) begin
      r_scrub_addr <= '0;
      r_pass_cnt   <= '0;
    end else if (w_scrub_wr) begin
      r_scrub_addr <= r_scrub_addr + GSH_PHT_SEL'(1);
      if (&r_scrub_addr) r_pass_cnt <= r_pass_cnt + PCW'(1);
    end
  end

  // wcond/went hold their last values whenever no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pht_we    <= 1'b0;
      r_pht_wcond <= 1'b0;
      r_pht_went  <= '0;
    end else if (w_scrub_wr) begin
      r_pht_we    <= 1'b1;
      r_pht_wcond <= 1'b0;
      r_pht_went  <= r_scrub_addr;
    end else if (w_deq) begin
      r_pht_we    <= 1'b1;
      r_pht_wcond <= w_head.cond;
      r_pht_went  <= w_head.ent;
    end else begin
      r_pht_we    <= 1'b0;
    end
  end

  pht_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr0_en   (w_acc0),
    .i_wr0_data ('{cond: req0_cond, ent: req0_ent}),
    .i_wr1_en   (w_acc1),
    .i_wr1_data ('{cond: req1_cond, ent: req1_ent}),
    .i_rd_en    (w_deq),
    .o_rd_data  (w_head),
    .o_count    (w_count)
  );

  assign pht_we     = r_pht_we;
  assign pht_wcond  = r_pht_wcond;
  assign pht_went   = r_pht_went;
  assign scrub_busy = (r_state == ST_SCRUB);
  assign fifo_count = w_count;

endmodule

// File: tb/tb_pht_update_sched.sv
module tb_pht_update_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_cond, req0_ready;
  logic [9:0] req0_ent;
  logic       req1_valid, req1_cond, req1_ready;
  logic [9:0] req1_ent;
  logic       scrub_req;
  logic       pht_we, pht_wcond;
  logic [9:0] pht_went;
  logic       scrub_busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q [$];

  pht_update_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_cond  (req0_cond),
    .req0_ent   (req0_ent),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_cond  (req1_cond),
    .req1_ent   (req1_ent),
    .req1_ready (req1_ready),
    .scrub_req  (scrub_req),
    .pht_we     (pht_we),
    .pht_wcond  (pht_wcond),
    .pht_went   (pht_went),
    .scrub_busy (scrub_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every non-scrub PHT write must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && pht_we === 1'b1 && scrub_busy === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual cond=%0b ent=%03h required no write", pht_wcond, pht_went);
      end else begin
        logic [10:0] exp_e;
        exp_e = exp_q.pop_front();
        if ({pht_wcond, pht_went} !== exp_e) begin
          failures++;
          $display("FAIL write_order actual cond=%0b ent=%03h required cond=%0b ent=%03h",
                   pht_wcond, pht_went, exp_e[10], exp_e[9:0]);
        end
      end
    end
  end

  task automatic set_req(input logic v0, input logic c0, input logic [9:0] e0,
                         input logic v1, input logic c1, input logic [9:0] e1);
    req0_valid = v0; req0_cond = c0; req0_ent = e0;
    req1_valid = v1; req1_cond = c1; req1_ent = e1;
  endtask

  // Called at a negedge whose next rising edge issues scrub write 0.
  task automatic run_scrub_check(input string name, input logic [2:0] exp_cnt, input bit inject);
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < 3072; i++) begin
      @(negedge clk);
      if (pht_we !== 1'b1 || pht_wcond !== 1'b0 || pht_went !== 10'(i % 1024) ||
          scrub_busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          fifo_count !== exp_cnt) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      if (inject) scrub_req = (i == 100);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_scrub_pattern actual bad_cycles=%0d first_at=%0d required bad_cycles=0", name, bad, first_bad);
    end
    @(negedge clk);
    checks++;
    if ({scrub_busy, pht_we} !== 2'b00) begin
      failures++;
      $display("FAIL %s_scrub_end actual busy=%0b we=%0b required busy=0 we=0", name, scrub_busy, pht_we);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || fifo_count !== 3'd0 || pht_we !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain actual pending=%0d count=%0d we=%0b required pending=0 count=0 we=0",
               name, exp_q.size(), fifo_count, pht_we);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    scrub_req = 1'b0;
    set_req(0, 0, '0, 0, 0, '0);
    repeat (3) @(negedge clk);
    checks++;
    if ({pht_we, pht_wcond, pht_went} !== 12'h000) begin
      failures++;
      $display("FAIL reset_write_port actual we=%0b cond=%0b ent=%03h required 0/0/000", pht_we, pht_wcond, pht_went);
    end
    checks++;
    if ({scrub_busy, req0_ready, req1_ready, fifo_count} !== 6'b100_000) begin
      failures++;
      $display("FAIL reset_status actual busy=%0b r0=%0b r1=%0b count=%0d required 1/0/0/0",
               scrub_busy, req0_ready, req1_ready, fifo_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({scrub_busy, req0_ready, req1_ready, pht_we} !== 4'b1000) begin
      failures++;
      $display("FAIL post_reset_status actual busy=%0b r0=%0b r1=%0b we=%0b required 1/0/0/0",
               scrub_busy, req0_ready, req1_ready, pht_we);
    end
    run_scrub_check("initial", 3'd0, 1'b0);
  endtask

  task automatic test_both_units();
    @(posedge clk); #1; set_req(1, 1, 10'h155, 1, 0, 10'h2AA);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b11) begin
      failures++;
      $display("FAIL both_ready actual r0=%0b r1=%0b required 1/1", req0_ready, req1_ready);
    end
    exp_q.push_back({1'b1, 10'h155});
    exp_q.push_back({1'b0, 10'h2AA});
    @(posedge clk); #1; set_req(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    checks++;
    if ({fifo_count, pht_we} !== {3'd2, 1'b0}) begin
      failures++;
      $display("FAIL both_enqueued actual count=%0d we=%0b required 2/0", fifo_count, pht_we);
    end
    @(negedge clk);
    checks++;
    if ({pht_we, pht_wcond, pht_went} !== {1'b1, 1'b1, 10'h155}) begin
      failures++;
      $display("FAIL both_first_write actual we=%0b cond=%0b ent=%03h required 1/1/155", pht_we, pht_wcond, pht_went);
    end
    @(negedge clk);
    checks++;
    if ({pht_we, pht_wcond, pht_went} !== {1'b1, 1'b0, 10'h2AA}) begin
      failures++;
      $display("FAIL both_second_write actual we=%0b cond=%0b ent=%03h required 1/0/2AA", pht_we, pht_wcond, pht_went);
    end
    wait_drain("both");
  endtask

  task automatic test_full_boundary();
    @(posedge clk); #1; set_req(1, 0, 10'h001, 1, 1, 10'h002);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b11) begin
      failures++;
      $display("FAIL bnd_ready_c0 actual r0=%0b r1=%0b required 1/1", req0_ready, req1_ready);
    end
    exp_q.push_back({1'b0, 10'h001});
    exp_q.push_back({1'b1, 10'h002});
    @(posedge clk); #1; set_req(1, 1, 10'h003, 1, 0, 10'h004);
    @(negedge clk);
    checks++;
    if ({fifo_count, req0_ready, req1_ready} !== {3'd2, 2'b11}) begin
      failures++;
      $display("FAIL bnd_ready_c2 actual count=%0d r0=%0b r1=%0b required 2/1/1", fifo_count, req0_ready, req1_ready);
    end
    exp_q.push_back({1'b1, 10'h003});
    exp_q.push_back({1'b0, 10'h004});
    @(posedge clk); #1; set_req(1, 1, 10'h005, 1, 1, 10'h006);
    @(negedge clk);
    checks++;
    if ({fifo_count, req0_ready, req1_ready} !== {3'd3, 2'b10}) begin
      failures++;
      $display("FAIL bnd_ready_c3 actual count=%0d r0=%0b r1=%0b required 3/1/0", fifo_count, req0_ready, req1_ready);
    end
    exp_q.push_back({1'b1, 10'h005});
    @(posedge clk); #1; set_req(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL bnd_count_after_enq_deq actual count=%0d required 3", fifo_count);
    end
    wait_drain("boundary");
  endtask

  task automatic test_scrub_req();
    @(posedge clk); #1; set_req(1, 0, 10'h307, 1, 1, 10'h008); scrub_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b11) begin
      failures++;
      $display("FAIL scrubreq_ready actual r0=%0b r1=%0b required 1/1", req0_ready, req1_ready);
    end
    exp_q.push_back({1'b0, 10'h307});
    exp_q.push_back({1'b1, 10'h008});
    @(posedge clk); #1; set_req(0, 0, '0, 0, 0, '0); scrub_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({scrub_busy, pht_we, fifo_count} !== {2'b10, 3'd2}) begin
      failures++;
      $display("FAIL scrubreq_entry actual busy=%0b we=%0b count=%0d required 1/0/2", scrub_busy, pht_we, fifo_count);
    end
    run_scrub_check("scrubreq", 3'd2, 1'b1);
    wait_drain("scrubreq");
  endtask

  task automatic test_full_dequeue();
    @(posedge clk); #1; set_req(1, 1, 10'h011, 1, 0, 10'h022);
    @(negedge clk);
    exp_q.push_back({1'b1, 10'h011});
    exp_q.push_back({1'b0, 10'h022});
    @(posedge clk); #1; set_req(1, 0, 10'h033, 1, 1, 10'h044); scrub_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({fifo_count, req0_ready, req1_ready} !== {3'd2, 2'b11}) begin
      failures++;
      $display("FAIL full_fill actual count=%0d r0=%0b r1=%0b required 2/1/1", fifo_count, req0_ready, req1_ready);
    end
    exp_q.push_back({1'b0, 10'h033});
    exp_q.push_back({1'b1, 10'h044});
    @(posedge clk); #1; set_req(0, 0, '0, 0, 0, '0); scrub_req = 1'b0;
    @(negedge clk);
    run_scrub_check("full", 3'd4, 1'b0);
    checks++;
    if ({fifo_count, req0_ready, req1_ready} !== {3'd4, 2'b00}) begin
      failures++;
      $display("FAIL full_not_ready actual count=%0d r0=%0b r1=%0b required 4/0/0", fifo_count, req0_ready, req1_ready);
    end
    set_req(1, 1, 10'h3FF, 1, 1, 10'h3FE);
    @(posedge clk); #1; set_req(0, 0, '0, 0, 0, '0);
    @(negedge clk);
    checks++;
    if ({fifo_count, req0_ready, req1_ready} !== {3'd3, 2'b10}) begin
      failures++;
      $display("FAIL full_after_deq actual count=%0d r0=%0b r1=%0b required 3/1/0", fifo_count, req0_ready, req1_ready);
    end
    wait_drain("full");
  endtask

  task automatic test_reset_mid_drain();
    int bad = 0;
    @(posedge clk); #1; set_req(1, 1, 10'h0A0, 1, 1, 10'h0B0);
    @(negedge clk);
    @(posedge clk); #1; set_req(1, 0, 10'h0C0, 1, 1, 10'h0D0);
    @(negedge clk);
    @(posedge clk); #1; set_req(0, 0, '0, 0, 0, '0);
    checks++;
    if ({fifo_count, pht_we} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL middrain_setup actual count=%0d we=%0b required 3/1", fifo_count, pht_we);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({pht_we, scrub_busy, fifo_count, req0_ready, req1_ready} !== {2'b01, 3'd0, 2'b00}) begin
      failures++;
      $display("FAIL middrain_reset actual we=%0b busy=%0b count=%0d r0=%0b r1=%0b required 0/1/0/0/0",
               pht_we, scrub_busy, fifo_count, req0_ready, req1_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_scrub_check("middrain", 3'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (pht_we !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL middrain_no_writes actual bad_cycles=%0d required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_both_units();
    test_full_boundary();
    test_scrub_req();
    test_full_dequeue();
    test_reset_mid_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending actual pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
